dmem_bus_bridge: RTL and testbench

//   Sits downstream of the CPU core's MEM stage, between the core data-memory port and a valid/ready memory bus.

---
 rtl/dmem_bus_bridge.sv | 138 +++++++++++++
 tb/tb_dmem_bus_bridge.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_bridge.sv
// Data-memory bridge between the core MEM stage and a valid/ready bus.
// Stores post into an in-order write buffer. Loads drain the buffer first,
// then issue the read and hold the pipeline until the response returns.
module dmem_bus_bridge #(
  parameter int WB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 core_addr,
  input  logic [31:0]                 core_wdata,
  input  logic [3:0]                  core_wen,
  input  logic                        core_ren,
  output logic [31:0]                 core_rdata,
  output logic                        core_stall,
  output logic                        bus_req_valid,
  input  logic                        bus_req_ready,
  output logic                        bus_req_we,
  output logic [31:0]                 bus_req_addr,
  output logic [31:0]                 bus_req_wdata,
  output logic [3:0]                  bus_req_wstrb,
  input  logic                        bus_rsp_valid,
  input  logic [31:0]                 bus_rsp_rdata,
  output logic [$clog2(WB_DEPTH):0]   wb_count
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {IDLE, DRAIN, RD_REQ, RD_WAIT, RD_DONE} state_t;

  state_t state, state_nx;

  logic [31:0] wb_addr  [WB_DEPTH];
  logic [31:0] wb_wdata [WB_DEPTH];
  logic [3:0]  wb_wstrb [WB_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic store, full, empty, push, pop, wb_drive;

  assign store    = (core_wen != 4'b0000);
  assign full     = (count == CW'(WB_DEPTH));
  assign empty    = (count == '0);
  // Full is judged on the registered count, so a pop in the same cycle
  // does not let a blocked store slip in early.
  assign push     = store && !full;
  assign wb_drive = ((state == IDLE) || (state == DRAIN)) && !empty;
  assign pop      = wb_drive && bus_req_ready;
  assign wb_count = count;

  // Buffer storage has no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr[wr_ptr]  <= core_addr;
      wb_wdata[wr_ptr] <= core_wdata;
      wb_wstrb[wr_ptr] <= core_wen;
    end
  end

  // Buffer pointers and occupancy; reset drops any buffered writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // FSM state register; reset abandons any in-flight read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Load data capture; only a response seen while waiting is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     core_rdata <= '0;
    else if (state == RD_WAIT && bus_rsp_valid)  core_rdata <= bus_rsp_rdata;
  end

  // Next state, stall and bus request; the write-buffer head owns the bus
  // in IDLE/DRAIN, the load owns it in RD_REQ.
  always_comb begin
    state_nx      = state;
    core_stall    = 1'b0;
    bus_req_valid = 1'b0;
    bus_req_we    = 1'b0;
    bus_req_addr  = '0;
    bus_req_wdata = '0;
    bus_req_wstrb = '0;
    if (wb_drive) begin
      bus_req_valid = 1'b1;
      bus_req_we    = 1'b1;
      bus_req_addr  = wb_addr[rd_ptr] & 32'hFFFF_FFFC;
      bus_req_wdata = wb_wdata[rd_ptr];
      bus_req_wstrb = wb_wstrb[rd_ptr];
    end
    case (state)
      IDLE: begin
        if (store) begin
          core_stall = full;
        end else if (core_ren) begin
          core_stall = 1'b1;
          state_nx   = empty ? RD_REQ : DRAIN;
        end
      end
      DRAIN: begin
        core_stall = 1'b1;
        if (empty || (count == CW'(1) && pop)) state_nx = RD_REQ;
      end
      RD_REQ: begin
        core_stall    = 1'b1;
        bus_req_valid = 1'b1;
        bus_req_we    = 1'b0;
        bus_req_addr  = core_addr & 32'hFFFF_FFFC;
        bus_req_wdata = '0;
        bus_req_wstrb = '0;
        if (bus_req_ready) state_nx = RD_WAIT;
      end
      RD_WAIT: begin
        core_stall = 1'b1;
        if (bus_rsp_valid) state_nx = RD_DONE;
      end
      RD_DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed bench for dmem_bus_bridge with a small posted-write / read-response
// bus model that logs every accepted transaction in order.
module tb_dmem_bus_bridge;

  logic        clk, rst;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic [3:0]  core_wen;
  logic        core_ren, core_stall;
  logic        bus_req_valid, bus_req_ready, bus_req_we;
  logic [31:0] bus_req_addr, bus_req_wdata;
  logic [3:0]  bus_req_wstrb;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_rdata;
  logic [2:0]  wb_count;

  int checks = 0;
  int errors = 0;

  logic        ready_en = 1'b0;
  logic        rsp_hold = 1'b0;
  logic        inject_rsp = 1'b0;
  logic [31:0] inject_data = '0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } txn_t;

  txn_t        log_q[$];
  logic [31:0] mem [logic [31:0]];

  assign bus_req_ready = ready_en;

  dmem_bus_bridge #(.WB_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_wen(core_wen), .core_ren(core_ren),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_we(bus_req_we),
    .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata), .wb_count(wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus model: commits writes to memory, answers reads one cycle after accept.
  initial begin
    bus_rsp_valid = 1'b0;
    bus_rsp_rdata = '0;
    forever begin
      @(posedge clk);
      bus_rsp_valid <= 1'b0;
      if (bus_req_valid && bus_req_ready) begin
        txn_t t;
        t.we = bus_req_we; t.addr = bus_req_addr; t.data = bus_req_wdata; t.strb = bus_req_wstrb;
        log_q.push_back(t);
        if (bus_req_we) begin
          logic [31:0] w;
          w = mem.exists(bus_req_addr) ? mem[bus_req_addr] : 32'h0;
          for (int b = 0; b < 4; b++)
            if (bus_req_wstrb[b]) w[8*b +: 8] = bus_req_wdata[8*b +: 8];
          mem[bus_req_addr] = w;
        end else if (!rsp_hold) begin
          bus_rsp_valid <= 1'b1;
          bus_rsp_rdata <= mem.exists(bus_req_addr) ? mem[bus_req_addr] : 32'h0;
        end
      end
      if (inject_rsp) begin
        bus_rsp_valid <= 1'b1;
        bus_rsp_rdata <= inject_data;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; core_addr = '0; core_wdata = '0; core_wen = '0; core_ren = 1'b0;
    #2;
    checks++; if (core_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %b expected 0", core_stall); end
    checks++; if (bus_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b expected 0", bus_req_valid); end
    checks++; if (wb_count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count got %0d expected 0", wb_count); end
    checks++; if (core_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata got %h expected 0", core_rdata); end
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single_store();
    ready_en = 1'b1;
    core_addr = 32'h100; core_wdata = 32'hDEADBEEF; core_wen = 4'b1111;
    #1;
    checks++; if (core_stall !== 1'b0) begin errors++; $display("[TB] FAIL st1_stall got %b expected 0", core_stall); end
    tick();
    core_wen = 4'b0000;
    #1;
    checks++; if (bus_req_valid !== 1'b1 || bus_req_we !== 1'b1) begin errors++; $display("[TB] FAIL st1_req got v=%b we=%b expected v=1 we=1", bus_req_valid, bus_req_we); end
    checks++; if (bus_req_addr !== 32'h100) begin errors++; $display("[TB] FAIL st1_addr got %h expected 00000100", bus_req_addr); end
    checks++; if (bus_req_wstrb !== 4'b1111) begin errors++; $display("[TB] FAIL st1_wstrb got %b expected 1111", bus_req_wstrb); end
    checks++; if (bus_req_wdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL st1_wdata got %h expected deadbeef", bus_req_wdata); end
    checks++; if (wb_count !== 3'd1) begin errors++; $display("[TB] FAIL st1_count got %0d expected 1", wb_count); end
    tick();
    checks++; if (wb_count !== 3'd0) begin errors++; $display("[TB] FAIL st1_drained got %0d expected 0", wb_count); end
    checks++; if (log_q.size() !== 1) begin errors++; $display("[TB] FAIL st1_log got %0d expected 1", log_q.size()); end
  endtask

  task automatic test_store_then_load();
    int base;
    base = log_q.size();
    ready_en = 1'b0;
    core_addr = 32'h104; core_wdata = 32'h12345678; core_wen = 4'b1111;
    #1;
    checks++; if (core_stall !== 1'b0) begin errors++; $display("[TB] FAIL st2_stall got %b expected 0", core_stall); end
    tick();
    core_wen = 4'b0000; core_ren = 1'b1; core_wdata = '0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (core_stall !== 1'b1 || bus_req_we !== 1'b1 || bus_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL ld2_drain%0d got stall=%b v=%b we=%b expected 1 1 1", i, core_stall, bus_req_valid, bus_req_we); end
      if (i < 3) tick();
    end
    ready_en = 1'b1;
    tick();
    checks++; if (bus_req_valid !== 1'b1 || bus_req_we !== 1'b0 || bus_req_addr !== 32'h104 || bus_req_wstrb !== 4'b0000) begin errors++; $display("[TB] FAIL ld2_rdreq got v=%b we=%b a=%h s=%b expected 1 0 00000104 0000", bus_req_valid, bus_req_we, bus_req_addr, bus_req_wstrb); end
    for (int i = 0; i < 10 && core_stall; i++) tick();
    checks++; if (core_stall !== 1'b0) begin errors++; $display("[TB] FAIL ld2_timeout got stall=%b expected 0", core_stall); end
    checks++; if (core_rdata !== 32'h12345678) begin errors++; $display("[TB] FAIL ld2_rdata got %h expected 12345678", core_rdata); end
    core_ren = 1'b0;
    checks++;
    if (log_q.size() < base + 2) begin errors++; $display("[TB] FAIL ld2_order got %0d txns expected %0d", log_q.size() - base, 2); end
    else if (log_q[base].we !== 1'b1 || log_q[base].addr !== 32'h104 || log_q[base+1].we !== 1'b0 || log_q[base+1].addr !== 32'h104) begin
      errors++; $display("[TB] FAIL ld2_order got we=%b,%b expected 1,0 at 00000104", log_q[base].we, log_q[base+1].we);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int base;
    base = log_q.size();
    ready_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      core_addr = 32'h400 + 32'(4 * i); core_wdata = 32'h1111_1111 * 32'(i + 1); core_wen = 4'b1111;
      #1;
      checks++; if (core_stall !== 1'b0) begin errors++; $display("[TB] FAIL b2b_nostall%0d got %b expected 0", i, core_stall); end
      tick();
    end
    core_addr = 32'h410; core_wdata = 32'h5555_5555;
    #1;
    checks++; if (core_stall !== 1'b1 || wb_count !== 3'd4) begin errors++; $display("[TB] FAIL b2b_full got stall=%b count=%0d expected 1 4", core_stall, wb_count); end
    tick();
    checks++; if (core_stall !== 1'b1 || wb_count !== 3'd4) begin errors++; $display("[TB] FAIL b2b_hold got stall=%b count=%0d expected 1 4", core_stall, wb_count); end
    ready_en = 1'b1;
    #1;
    checks++; if (core_stall !== 1'b1) begin errors++; $display("[TB] FAIL b2b_popcycle got stall=%b expected 1", core_stall); end
    tick();
    checks++; if (core_stall !== 1'b0 || wb_count !== 3'd3) begin errors++; $display("[TB] FAIL b2b_afterpop got stall=%b count=%0d expected 0 3", core_stall, wb_count); end
    tick();
    core_wen = 4'b0000;
    #1;
    checks++; if (wb_count !== 3'd3) begin errors++; $display("[TB] FAIL b2b_enq5 got count=%0d expected 3", wb_count); end
    for (int i = 0; i < 20 && wb_count != 0; i++) tick();
    checks++; if (wb_count !== 3'd0) begin errors++; $display("[TB] FAIL b2b_timeout got count=%0d expected 0", wb_count); end
    for (int i = 0; i < 5; i++) begin
      logic [31:0] ea, ed;
      ea = 32'h400 + 32'(4 * i);
      ed = (i == 4) ? 32'h5555_5555 : 32'h1111_1111 * 32'(i + 1);
      checks++;
      if (log_q.size() <= base + i) begin errors++; $display("[TB] FAIL b2b_order%0d got missing txn expected %h", i, ea); end
      else if (log_q[base+i].addr !== ea || log_q[base+i].data !== ed || log_q[base+i].we !== 1'b1) begin
        errors++; $display("[TB] FAIL b2b_order%0d got %h=%h expected %h=%h", i, log_q[base+i].addr, log_q[base+i].data, ea, ed);
      end
    end
  endtask

  task automatic test_load_zero_wait();
    int cnt;
    mem[32'h200] = 32'hA5A5A5A5;
    ready_en = 1'b1;
    core_addr = 32'h200; core_ren = 1'b1;
    #1;
    cnt = 0;
    while (core_stall && cnt < 10) begin cnt++; tick(); end
    checks++; if (cnt !== 3) begin errors++; $display("[TB] FAIL ld4_stallcycles got %0d expected 3", cnt); end
    checks++; if (core_rdata !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL ld4_rdata got %h expected a5a5a5a5", core_rdata); end
    core_ren = 1'b0;
    tick();
  endtask

  task automatic test_byte_store();
    ready_en = 1'b0;
    core_addr = 32'h301; core_wdata = 32'h0000AB00; core_wen = 4'b0010;
    #1;
    checks++; if (core_stall !== 1'b0) begin errors++; $display("[TB] FAIL bs_stall got %b expected 0", core_stall); end
    tick();
    core_wen = 4'b0000;
    #1;
    checks++; if (bus_req_valid !== 1'b1 || bus_req_addr !== 32'h300) begin errors++; $display("[TB] FAIL bs_addr got v=%b a=%h expected 1 00000300", bus_req_valid, bus_req_addr); end
    checks++; if (bus_req_wstrb !== 4'b0010) begin errors++; $display("[TB] FAIL bs_wstrb got %b expected 0010", bus_req_wstrb); end
    checks++; if (bus_req_wdata !== 32'h0000AB00) begin errors++; $display("[TB] FAIL bs_wdata got %h expected 0000ab00", bus_req_wdata); end
    ready_en = 1'b1;
    tick();
    checks++; if (wb_count !== 3'd0) begin errors++; $display("[TB] FAIL bs_drained got %0d expected 0", wb_count); end
  endtask

  task automatic test_reset_mid_op();
    int base, cnt;
    ready_en = 1'b0;
    core_addr = 32'h600; core_wdata = 32'h6666_6666; core_wen = 4'b1111;
    tick();
    core_addr = 32'h604;
    tick();
    core_wen = 4'b0000;
    #1;
    checks++; if (wb_count !== 3'd2) begin errors++; $display("[TB] FAIL rst_prefill got %0d expected 2", wb_count); end
    rst = 1'b1;
    #1;
    checks++; if (wb_count !== 3'd0 || bus_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_dropwb got count=%0d v=%b expected 0 0", wb_count, bus_req_valid); end
    tick();
    rst = 1'b0; ready_en = 1'b1;
    base = log_q.size();
    tick(); tick();
    checks++; if (log_q.size() !== base) begin errors++; $display("[TB] FAIL rst_nowrite got %0d txns expected 0", log_q.size() - base); end
    rsp_hold = 1'b1;
    core_addr = 32'h500; core_ren = 1'b1;
    tick(); tick();
    checks++; if (core_stall !== 1'b1 || bus_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_rdwait got stall=%b v=%b expected 1 0", core_stall, bus_req_valid); end
    core_ren = 1'b0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    inject_data = 32'hBAD0BAD0; inject_rsp = 1'b1;
    tick();
    inject_rsp = 1'b0;
    tick();
    checks++; if (core_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_late_rdata got %h expected 0", core_rdata); end
    checks++; if (core_stall !== 1'b0 || wb_count !== 3'd0 || bus_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_late_state got stall=%b count=%0d v=%b expected 0 0 0", core_stall, wb_count, bus_req_valid); end
    rsp_hold = 1'b0;
    core_addr = 32'h200; core_ren = 1'b1;
    #1;
    cnt = 0;
    while (core_stall && cnt < 10) begin cnt++; tick(); end
    checks++; if (cnt !== 3 || core_rdata !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL rst_idle_load got cycles=%0d rdata=%h expected 3 a5a5a5a5", cnt, core_rdata); end
    core_ren = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_store_then_load();
    test_back_to_back();
    test_load_zero_wait();
    test_byte_store();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
